// File: rtl/insn_decode.sv
// Registered RV32I instruction field decoder: slices fields, builds the immediate, flags illegal encodings.
// Optional macro RV32M_EN: accept ALU funct7=0000001 (MUL..REMU) as a legal encoding.
module insn_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [31:0]     insn,
  output logic            out_valid,
  output logic [4:0]      opcode,
  output logic [6:0]      funct7,
  output logic [2:0]      funct3,
  output logic            invalid,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm
);
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_ALUIMM = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ALU    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [4:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm_d;
  logic        bad_d;

  assign op = insn[6:2];
  assign f3 = insn[14:12];
  assign f7 = insn[31:25];

  assign imm_i = {{20{insn[31]}}, insn[31:20]};
  assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u = {insn[31:12], 12'b0};
  assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  always_comb begin
    imm_d = '0;
    bad_d = 1'b0;
    case (op)
      OP_LOAD: begin
        imm_d = imm_i;
        bad_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_MISC, OP_SYSTEM: imm_d = imm_i;
      OP_ALUIMM: begin
        imm_d = imm_i;
        // shift-immediates reuse the upper imm bits as funct7
        if (f3 == 3'b001)
          bad_d = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          bad_d = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OP_AUIPC, OP_LUI: imm_d = imm_u;
      OP_STORE: begin
        imm_d = imm_s;
        bad_d = (f3 >= 3'b011);
      end
      OP_ALU: begin
        case (f7)
          7'b0000000: bad_d = 1'b0;
          7'b0100000: bad_d = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef RV32M_EN
          7'b0000001: bad_d = 1'b0;
`else
          7'b0000001: bad_d = 1'b1;
`endif
          default:    bad_d = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        imm_d = imm_b;
        bad_d = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_JALR: begin
        imm_d = imm_i;
        bad_d = (f3 != 3'b000);
      end
      OP_JAL: imm_d = imm_j;
      default: bad_d = 1'b1;
    endcase
    if (insn[1:0] != 2'b11) bad_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      opcode    <= '0;
      funct7    <= '0;
      funct3    <= '0;
      invalid   <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
    end else if (en) begin
      out_valid <= 1'b1;
      opcode    <= op;
      funct7    <= f7;
      funct3    <= f3;
      invalid   <= bad_d;
      rd        <= insn[11:7];
      rs1       <= insn[19:15];
      rs2       <= insn[24:20];
      imm       <= imm_d[XLEN-1:0];
    end
  end
endmodule

// File: tb/tb_insn_decode.sv
// Directed-vector bench for insn_decode; RV32M_EN selects the expected legality of MUL.
module tb_insn_decode;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] insn = '0;
  logic        out_valid;
  logic [4:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        invalid;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  int checks = 0;
  int failures = 0;

  insn_decode #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .en(en), .insn(insn),
    .out_valid(out_valid), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .invalid(invalid), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm)
  );

  always #5 clk = ~clk;

  // Present one word with en high for a single edge, then sample 1 time unit later.
  task automatic drive(input logic [31:0] w);
    insn = w;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, opcode, funct7, funct3, invalid, rd, rs1, rs2, imm} !== '0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b op=%b imm=%h inv=%b, want all 0", out_valid, opcode, imm, invalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_itype();
    drive(32'hFFF00093);
    checks++;
    if (out_valid !== 1'b1 || opcode !== 5'b00100 || rd !== 5'd1 || rs1 !== 5'd0 || funct3 !== 3'b000) begin
      failures++;
      $display("FAIL addi_fields: got v=%b op=%b rd=%0d rs1=%0d f3=%b, want 1 00100 1 0 000", out_valid, opcode, rd, rs1, funct3);
    end
    checks++;
    if (imm !== 32'hFFFFFFFF || invalid !== 1'b0) begin
      failures++;
      $display("FAIL addi_imm: got imm=%h inv=%b, want ffffffff 0", imm, invalid);
    end
    drive(32'h40315093); // srai x1,x2,3
    checks++;
    if (invalid !== 1'b0 || imm !== 32'h00000403 || funct7 !== 7'b0100000) begin
      failures++;
      $display("FAIL srai: got inv=%b imm=%h f7=%b, want 0 00000403 0100000", invalid, imm, funct7);
    end
    drive(32'h40311093); // slli with funct7 0100000
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL slli_bad_f7: got inv=%b, want 1", invalid);
    end
  endtask

  task automatic test_store();
    drive(32'h0020A423);
    checks++;
    if (opcode !== 5'b01000 || rs1 !== 5'd1 || rs2 !== 5'd2 || funct3 !== 3'b010 || imm !== 32'h8 || invalid !== 1'b0) begin
      failures++;
      $display("FAIL sw: got op=%b rs1=%0d rs2=%0d f3=%b imm=%h inv=%b, want 01000 1 2 010 00000008 0",
               opcode, rs1, rs2, funct3, imm, invalid);
    end
    drive(32'h00003023);
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL store_f3_011: got inv=%b, want 1", invalid);
    end
  endtask

  task automatic test_branch_upper_jump();
    drive(32'hFE000EE3);
    checks++;
    if (opcode !== 5'b11000 || imm !== 32'hFFFFFFFC || invalid !== 1'b0) begin
      failures++;
      $display("FAIL beq: got op=%b imm=%h inv=%b, want 11000 fffffffc 0", opcode, imm, invalid);
    end
    drive(32'h123452B7);
    checks++;
    if (rd !== 5'd5 || imm !== 32'h12345000 || opcode !== 5'b01101) begin
      failures++;
      $display("FAIL lui: got rd=%0d imm=%h op=%b, want 5 12345000 01101", rd, imm, opcode);
    end
    drive(32'h001000EF);
    checks++;
    if (opcode !== 5'b11011 || rd !== 5'd1 || imm !== 32'h00000800 || invalid !== 1'b0) begin
      failures++;
      $display("FAIL jal: got op=%b rd=%0d imm=%h inv=%b, want 11011 1 00000800 0", opcode, rd, imm, invalid);
    end
  endtask

  task automatic test_illegal();
    drive(32'h00000000);
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL zero_word: got inv=%b, want 1", invalid);
    end
    drive(32'h00002063); // branch funct3 010
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL branch_f3_010: got inv=%b, want 1", invalid);
    end
    drive(32'h00003003); // load funct3 011
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL load_f3_011: got inv=%b, want 1", invalid);
    end
    drive(32'h00001067); // jalr funct3 001
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL jalr_f3: got inv=%b, want 1", invalid);
    end
    drive(32'hFFFFF00B); // opcode 00010 not in map
    checks++;
    if (invalid !== 1'b1 || imm !== 32'h0 || opcode !== 5'b00010) begin
      failures++;
      $display("FAIL unknown_op: got inv=%b imm=%h op=%b, want 1 00000000 00010", invalid, imm, opcode);
    end
    drive(32'hFFF00091); // addi encoding with low bits 01
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL low_bits: got inv=%b, want 1", invalid);
    end
  endtask

  task automatic test_alu();
    drive(32'h403100B3); // sub
    checks++;
    if (invalid !== 1'b0 || funct7 !== 7'b0100000 || rs2 !== 5'd3 || rs1 !== 5'd2) begin
      failures++;
      $display("FAIL sub: got inv=%b f7=%b rs2=%0d rs1=%0d, want 0 0100000 3 2", invalid, funct7, rs2, rs1);
    end
    drive(32'h403110B3); // sll with funct7 0100000
    checks++;
    if (invalid !== 1'b1) begin
      failures++;
      $display("FAIL sll_bad_f7: got inv=%b, want 1", invalid);
    end
    drive(32'h022081B3); // mul x3,x1,x2
    checks++;
`ifdef RV32M_EN
    if (invalid !== 1'b0 || rd !== 5'd3 || funct7 !== 7'b0000001) begin
      failures++;
      $display("FAIL mul: got inv=%b rd=%0d f7=%b, want 0 3 0000001", invalid, rd, funct7);
    end
`else
    if (invalid !== 1'b1 || rd !== 5'd3 || funct7 !== 7'b0000001) begin
      failures++;
      $display("FAIL mul: got inv=%b rd=%0d f7=%b, want 1 3 0000001", invalid, rd, funct7);
    end
`endif
  endtask

  task automatic test_hold_and_async_reset();
    drive(32'hFFF00093);
    insn = 32'h123452B7;
    en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || opcode !== 5'b00100 || imm !== 32'hFFFFFFFF || rd !== 5'd1) begin
      failures++;
      $display("FAIL hold: got v=%b op=%b imm=%h rd=%0d, want 1 00100 ffffffff 1", out_valid, opcode, imm, rd);
    end
    // back-to-back captures: each edge must show the word presented just before it
    insn = 32'h0020A423;
    en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (opcode !== 5'b01000 || imm !== 32'h8) begin
      failures++;
      $display("FAIL b2b_first: got op=%b imm=%h, want 01000 00000008", opcode, imm);
    end
    insn = 32'h001000EF;
    @(posedge clk); #1;
    checks++;
    if (opcode !== 5'b11011 || imm !== 32'h800) begin
      failures++;
      $display("FAIL b2b_second: got op=%b imm=%h, want 11011 00000800", opcode, imm);
    end
    // reset mid-cycle with en still high: must clear without waiting for an edge
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, opcode, funct7, funct3, invalid, rd, rs1, rs2, imm} !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b op=%b imm=%h rd=%0d, want all 0", out_valid, opcode, imm, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || imm !== 32'h0) begin
      failures++;
      $display("FAIL reset_dominates_en: got v=%b imm=%h, want 0 00000000", out_valid, imm);
    end
    rst = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_itype();
    test_store();
    test_branch_upper_jump();
    test_illegal();
    test_alu();
    test_hold_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
